adapter_in_high_perf: RTL and testbench

Input-side stream adapter for the high-performance Dilithium core.
- Accepts an external AXI-Stream-style 64-bit word stream and buffers it in a small FIFO.
- Forwards the buffered words to the core's input handshake.
- Admits exactly the word count implied by mode, sec_lvl and message length, then asserts done. Excess upstream words are back-pressured, never dropped.

---
 rtl/dilithium_io_pkg.sv | 54 +++++
 rtl/in_fifo.sv | 55 +++++
 rtl/adapter_in_high_perf.sv | 110 +++++++++++
 tb/tb_adapter_in_high_perf.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dilithium_io_pkg.sv
// Shared types and input-stream size table for the Dilithium I/O adapters.
// Sizes are in 64-bit words; MAX_IN_W covers the largest base plus a full 16-bit message length.
package dilithium_io_pkg;

  typedef enum logic [1:0] {
    KEYGEN = 2'd0,
    VERIFY = 2'd1,
    SIGN   = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_t;

  localparam int MAX_IN_W = 17;

  localparam logic [MAX_IN_W-1:0] KEYGEN_WORDS = 17'd4;
  localparam logic [MAX_IN_W-1:0] SK_WORDS_L2  = 17'd316;
  localparam logic [MAX_IN_W-1:0] SK_WORDS_L3  = 17'd500;
  localparam logic [MAX_IN_W-1:0] SK_WORDS_L5  = 17'd608;
  localparam logic [MAX_IN_W-1:0] VFY_WORDS_L2 = 17'd467;
  localparam logic [MAX_IN_W-1:0] VFY_WORDS_L3 = 17'd656;
  localparam logic [MAX_IN_W-1:0] VFY_WORDS_L5 = 17'd899;

  // Unknown security levels fall back to level 5; mode 3 has no payload.
  function automatic logic [MAX_IN_W-1:0] in_base_size(input logic [1:0] mode,
                                                       input logic [2:0] sec_lvl);
    logic [MAX_IN_W-1:0] size;
    size = '0;
    case (mode)
      KEYGEN: size = KEYGEN_WORDS;
      SIGN: begin
        case (sec_lvl)
          3'd2:    size = SK_WORDS_L2;
          3'd3:    size = SK_WORDS_L3;
          default: size = SK_WORDS_L5;
        endcase
      end
      VERIFY: begin
        case (sec_lvl)
          3'd2:    size = VFY_WORDS_L2;
          3'd3:    size = VFY_WORDS_L3;
          default: size = VFY_WORDS_L5;
        endcase
      end
      default: size = '0;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/in_fifo.sv
// Circular-buffer FIFO; a pushed word is visible at head one cycle later.
// Push is refused when full unless a pop happens in the same cycle; head reads 0 while empty.
module in_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE_PTR;
      if (do_pop)  rd_ptr <= rd_ptr + ONE_PTR;
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/adapter_in_high_perf.sv
// Input stream adapter: admits exactly the mode/level/length word count through a FIFO to the core, 1+ cycle latency.
// Upstream is stalled when the FIFO is full or the count is reached; LAST_CHECK_EN adds a sticky TLAST check on err.
module adapter_in_high_perf
  import dilithium_io_pkg::*;
#(
  parameter int w     = 64,
  parameter int DEPTH = 16,
  parameter int MSG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [2:0]       sec_lvl,
  input  logic [MSG_W-1:0] msg_len_words,
  input  logic             valid_i,
  output logic             ready_i,
  input  logic [w-1:0]     data_i,
  input  logic             last_i,
  output logic             dilithium_valid_i,
  input  logic             dilithium_ready_i,
  output logic [w-1:0]     dilithium_data_i,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [MAX_IN_W-1:0] ONE = MAX_IN_W'(1);

  fsm_state_t          state;
  logic [MAX_IN_W-1:0] in_rem;
  logic [MAX_IN_W-1:0] out_rem;
  logic [MAX_IN_W-1:0] in_rem_nxt;
  logic [MAX_IN_W-1:0] out_rem_nxt;
  logic [MAX_IN_W-1:0] total;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;

  always_comb begin
    total = in_base_size(mode, sec_lvl);
    if (mode == SIGN || mode == VERIFY) total = total + MAX_IN_W'(msg_len_words);
  end

  assign ready_i           = (state == ST_FILL) && !fifo_full && (in_rem != '0);
  assign push              = valid_i && ready_i;
  assign dilithium_valid_i = !fifo_empty;
  assign pop               = dilithium_valid_i && dilithium_ready_i;
  assign in_rem_nxt        = push ? in_rem - ONE : in_rem;
  assign out_rem_nxt       = (pop && out_rem != '0) ? out_rem - ONE : out_rem;
  assign busy              = (state != ST_IDLE);
  assign done              = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      in_rem  <= '0;
      out_rem <= '0;
    end else begin
      in_rem  <= in_rem_nxt;
      out_rem <= out_rem_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            in_rem  <= total;
            out_rem <= total;
            state   <= (total == '0) ? ST_DONE : ST_FILL;
          end
        end
        // The drain-complete check also covers FILL, where it can only fire once in_rem is already 0.
        ST_FILL, ST_DRAIN: begin
          if (out_rem_nxt == '0)     state <= ST_DONE;
          else if (in_rem_nxt == '0) state <= ST_DRAIN;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  in_fifo #(
    .WIDTH(w),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(data_i),
    .pop      (pop),
    .head     (dilithium_data_i),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef LAST_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           err_q <= 1'b0;
    else if (state == ST_IDLE && start) err_q <= 1'b0;
    else if (push && (last_i != (in_rem == ONE))) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  logic unused_last;
  assign unused_last = last_i;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_adapter_in_high_perf.sv
// Directed bench for adapter_in_high_perf with a word scoreboard between source and core side.
module tb_adapter_in_high_perf;

  localparam int W     = 64;
  localparam int DEPTH = 16;
  localparam int MSG_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       mode;
  logic [2:0]       sec_lvl;
  logic [MSG_W-1:0] msg_len_words;
  logic             valid_i;
  logic             ready_i;
  logic [W-1:0]     data_i;
  logic             last_i;
  logic             dilithium_valid_i;
  logic             dilithium_ready_i;
  logic [W-1:0]     dilithium_data_i;
  logic             busy;
  logic             done;
  logic             err;

  adapter_in_high_perf #(.w(W), .DEPTH(DEPTH), .MSG_W(MSG_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .mode             (mode),
    .sec_lvl          (sec_lvl),
    .msg_len_words    (msg_len_words),
    .valid_i          (valid_i),
    .ready_i          (ready_i),
    .data_i           (data_i),
    .last_i           (last_i),
    .dilithium_valid_i(dilithium_valid_i),
    .dilithium_ready_i(dilithium_ready_i),
    .dilithium_data_i (dilithium_data_i),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] sb[$];
  int          cyc = 0;
  int          src_idx, src_limit, last_pos, rdy_mod;
  logic [63:0] src_base;
  int          acc_cnt, out_cnt, done_cnt, done_cyc, last_pop_cyc, start_cyc;
  int          max_occ, full_viol, err_first_cyc, acc3_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    valid_i = (src_idx < src_limit);
    data_i  = src_base + 64'(src_idx);
    last_i  = valid_i && (src_idx == last_pos);
  endtask

  task automatic set_src(input logic [63:0] base, input int count, input int lpos);
    src_base  = base;
    src_idx   = 0;
    src_limit = count;
    last_pos  = lpos;
    drive_src();
  endtask

  task automatic clear_stats();
    sb.delete();
    acc_cnt = 0; out_cnt = 0; done_cnt = 0; done_cyc = -1; last_pop_cyc = -1;
    start_cyc = -1; max_occ = 0; full_viol = 0; err_first_cyc = -1; acc3_cyc = -1;
  endtask

  // One clock: sample handshakes at the falling edge, update inputs just after the rising edge.
  task automatic step();
    logic        acc, pop;
    logic [63:0] exp;
    @(negedge clk);
    acc = valid_i && ready_i;
    pop = dilithium_valid_i && dilithium_ready_i;
    if (start) start_cyc = cyc;
    if (sb.size() > max_occ) max_occ = sb.size();
    if (sb.size() == DEPTH && ready_i) full_viol++;
    if (err && err_first_cyc < 0) err_first_cyc = cyc;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (acc) begin
      sb.push_back(src_base + 64'(src_idx));
      acc_cnt++;
      if (acc_cnt == 3) acc3_cyc = cyc;
    end
    if (pop) begin
      if (sb.size() == 0) check("pop_underflow", 1'b1, 1'b0);
      else begin
        exp = sb.pop_front();
        check("core_data", dilithium_data_i, exp);
      end
      out_cnt++;
      last_pop_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc) src_idx++;
    drive_src();
    dilithium_ready_i = (rdy_mod <= 1) ? 1'b1 : ((cyc % rdy_mod) == 0);
  endtask

  task automatic do_start(input logic [1:0] m, input logic [2:0] lvl, input logic [15:0] len);
    start = 1'b1; mode = m; sec_lvl = lvl; msg_len_words = len;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, done_cnt == 0, 1'b0);
    repeat (4) step();
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; mode = '0; sec_lvl = '0; msg_len_words = '0;
    dilithium_ready_i = 1'b1; rdy_mod = 1;
    clear_stats();
    set_src(64'h0, 0, -1);

    @(negedge clk);
    check("rst_ctrl", {ready_i, dilithium_valid_i, busy, done, err}, 5'b0);
    check("rst_data", dilithium_data_i, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Keygen, level 2: four words A0..A3 with an always-ready core.
    clear_stats();
    set_src(64'hA0, 4, -1);
    do_start(2'd0, 3'd2, 16'd0);
    run_to_done(60, "kg");
    check("kg_acc", acc_cnt, 4);
    check("kg_out", out_cnt, 4);
    check("kg_done_cnt", done_cnt, 1);
    check("kg_done_lat", done_cyc - last_pop_cyc, 1);
    check("kg_ready_after", ready_i, 1'b0);
    check("kg_busy_after", busy, 1'b0);

    // Sign, level 3, 10 message words: 510 admitted out of 520 offered.
    clear_stats();
    set_src(64'h1000, 520, -1);
    do_start(2'd2, 3'd3, 16'd10);
    run_to_done(800, "sg");
    check("sg_acc", acc_cnt, 510);
    check("sg_out", out_cnt, 510);
    check("sg_done_cnt", done_cnt, 1);
    check("sg_done_lat", done_cyc - last_pop_cyc, 1);
    check("sg_held", {valid_i, ready_i}, 2'b10);
    check("sg_held_idx", src_idx, 510);
    set_src(64'h0, 0, -1);

    // Verify, level 5, no message, core ready one cycle in four.
    clear_stats();
    rdy_mod = 4;
    set_src(64'h5000_0000, 899, -1);
    do_start(2'd1, 3'd5, 16'd0);
    run_to_done(5000, "vf");
    rdy_mod = 1;
    dilithium_ready_i = 1'b1;
    check("vf_acc", acc_cnt, 899);
    check("vf_out", out_cnt, 899);
    check("vf_sb_empty", sb.size(), 0);
    check("vf_max_occ", max_occ, DEPTH);
    check("vf_full_stall", full_viol, 0);
    check("vf_done_cnt", done_cnt, 1);
    check("vf_done_lat", done_cyc - last_pop_cyc, 1);

    // Reset after 100 words of a sign transfer, then a clean full transfer.
    clear_stats();
    set_src(64'h7700_0000, 400, -1);
    do_start(2'd2, 3'd2, 16'd0);
    n = 0;
    while (acc_cnt < 100 && n < 500) begin
      step();
      n++;
    end
    check("mr_timeout", acc_cnt < 100, 1'b0);
    rst = 1'b1;
    #1;
    check("mr_async_ctrl", {ready_i, dilithium_valid_i, busy, done, err}, 5'b0);
    check("mr_async_data", dilithium_data_i, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_stats();
    set_src(64'h8800_0000, 400, -1);
    do_start(2'd2, 3'd2, 16'd0);
    run_to_done(800, "mr");
    check("mr_acc", acc_cnt, 316);
    check("mr_out", out_cnt, 316);
    check("mr_done_cnt", done_cnt, 1);
    set_src(64'h0, 0, -1);

    // Reserved mode: nothing admitted, done one cycle after start.
    clear_stats();
    set_src(64'hDEAD, 8, -1);
    do_start(2'd3, 3'd2, 16'd5);
    run_to_done(10, "m3");
    check("m3_done_lat", done_cyc - start_cyc, 1);
    check("m3_acc", acc_cnt, 0);
    check("m3_done_cnt", done_cnt, 1);
    check("m3_busy_after", busy, 1'b0);
    set_src(64'h0, 0, -1);

    // Keygen with TLAST on the third word instead of the fourth.
    clear_stats();
    set_src(64'hB0, 4, 2);
    do_start(2'd0, 3'd2, 16'd0);
    run_to_done(60, "lc");
    check("lc_acc", acc_cnt, 4);
    check("lc_out", out_cnt, 4);
`ifdef LAST_CHECK_EN
    check("lc_err_lat", err_first_cyc - acc3_cyc, 1);
    check("lc_err_sticky", err, 1'b1);
`else
    check("lc_err_never", err_first_cyc < 0, 1'b1);
`endif
    set_src(64'h0, 0, -1);
    clear_stats();
    do_start(2'd3, 3'd2, 16'd0);
    check("lc_err_cleared", err, 1'b0);
    run_to_done(10, "lc2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
